// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin share of one 8N1 UART TX pin between two byte streams.
// Optional idle-owner lock timeout with io_timeout pulse: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int CLK_DIV = 868
`ifdef UART_TX_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic       io_mainClk,
  input  logic       io_asyncReset,
  input  logic       io_req0_valid,
  input  logic [7:0] io_req0_data,
  input  logic       io_req0_last,
  output logic       io_req0_ready,
  input  logic       io_req1_valid,
  input  logic [7:0] io_req1_data,
  input  logic       io_req1_last,
  output logic       io_req1_ready,
  output logic       io_uart_txd,
  output logic       io_busy,
  output logic       io_locked,
  output logic       io_owner
`ifdef UART_TX_ARB_TIMEOUT_EN
  , output logic     io_timeout
`endif
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic owner_q, owner_d, locked_q, locked_d, ptr_q, ptr_d, txd_q, txd_d;
  logic idle, tick, acc, acc1;
  assign idle = state_q == IDLE;
  assign tick = div_q == 16'(CLK_DIV - 1);
  // ptr_q=1 means requester 1 wins a tie; the reset gate keeps ready low during reset
  assign io_req0_ready = !io_asyncReset && idle && io_req0_valid &&
                         (locked_q ? !owner_q : !(io_req1_valid && ptr_q));
  assign io_req1_ready = !io_asyncReset && idle && io_req1_valid &&
                         (locked_q ? owner_q : !(io_req0_valid && !ptr_q));
  assign acc = io_req0_ready || io_req1_ready;
  assign acc1 = io_req1_ready;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic timeout_q, stall, fire;
  assign stall = locked_q && idle && !(owner_q ? io_req1_valid : io_req0_valid);
  assign fire = stall && cnt_q == 32'(TIMEOUT_CYCLES - 1);
  assign cnt_d = (acc || !locked_q || fire) ? 32'd0 : cnt_q + {31'd0, stall};
  assign io_timeout = timeout_q;
`endif
  always_comb begin
    state_d = state_q;
    div_d = (idle || tick) ? 16'd0 : div_q + 16'd1;
    bit_d = bit_q;
    data_d = data_q;
    owner_d = owner_q;
    locked_d = locked_q;
    ptr_d = ptr_q;
    if (acc) begin
      state_d = START;
      data_d = acc1 ? io_req1_data : io_req0_data;
      owner_d = acc1;
      locked_d = !(acc1 ? io_req1_last : io_req0_last);
      ptr_d = !acc1;
    end else if (!idle && tick) begin
      state_d = state_q == START ? DATA : state_q == STOP ? IDLE : (bit_q == 3'd7 ? STOP : DATA);
      bit_d = state_q == DATA ? bit_q + 3'd1 : 3'd0;
    end
`ifdef UART_TX_ARB_TIMEOUT_EN
    if (fire) begin
      locked_d = 1'b0;
      ptr_d = !owner_q;
    end
`endif
    txd_d = state_d == DATA ? data_d[bit_d] : state_d != START;
  end
  always_ff @(posedge io_mainClk or posedge io_asyncReset)
    if (io_asyncReset) begin
      state_q <= IDLE;
      div_q <= 16'd0;
      bit_q <= 3'd0;
      data_q <= 8'd0;
      owner_q <= 1'b0;
      locked_q <= 1'b0;
      ptr_q <= 1'b0;
      txd_q <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q <= 32'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bit_q <= bit_d;
      data_q <= data_d;
      owner_q <= owner_d;
      locked_q <= locked_d;
      ptr_q <= ptr_d;
      txd_q <= txd_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      timeout_q <= fire;
`endif
    end
  assign io_uart_txd = txd_q;
  assign io_busy = !idle;
  assign io_locked = locked_q;
  assign io_owner = owner_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scenarios checked against a frame-level arbitration and waveform model.
module tb_uart_tx_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic r0, r1, txd, busy, locked, owner;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic tmo;
`endif
  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .CLK_DIV(4)
`ifdef UART_TX_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .io_mainClk(clk), .io_asyncReset(rst),
    .io_req0_valid(v0), .io_req0_data(d0), .io_req0_last(l0), .io_req0_ready(r0),
    .io_req1_valid(v1), .io_req1_data(d1), .io_req1_last(l1), .io_req1_ready(r1),
    .io_uart_txd(txd), .io_busy(busy), .io_locked(locked), .io_owner(owner)
`ifdef UART_TX_ARB_TIMEOUT_EN
    , .io_timeout(tmo)
`endif
  );

  typedef struct packed {logic last; logic [7:0] d;} byte_t;
  typedef struct {int t; int r; logic [7:0] d; logic last;} ev_t;
  byte_t q0[$], q1[$];
  int st0, st1;
  ev_t acc[$], exq[$];
  logic [3:0] obs[0:1023], ew[0:1023];
  logic tlog[0:1023];
  int checks = 0, errors = 0;

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    q0.delete();
    q1.delete();
    st0 = 0;
    st1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Frame-level model: one grant per free line slot, each frame occupying 41 cycles of the line.
  task automatic build_model(input int n);
    int i0, i1, t, last_srv, who, ta, k, j;
    bit lk, ow, a0, a1, tx;
    logic [7:0] b;
    byte_t x;
    i0 = 0; i1 = 0; t = 0; last_srv = -1; ta = -1000; j = 0; lk = 0; ow = 0; b = 8'h00;
    exq.delete();
    while (t < n) begin
      a0 = i0 < q0.size() && t >= st0;
      a1 = i1 < q1.size() && t >= st1;
      who = -1;
      if (lk) begin
        if (ow ? a1 : a0) who = ow ? 1 : 0;
      end else if (a0 && a1) who = (last_srv == 0) ? 1 : 0;
      else if (a0) who = 0;
      else if (a1) who = 1;
      if (who < 0) t++;
      else begin
        x = (who == 1) ? q1[i1] : q0[i0];
        exq.push_back('{t, who, x.d, x.last});
        if (who == 1) i1++; else i0++;
        lk = !x.last;
        ow = (who == 1);
        last_srv = who;
        t += 41;
      end
    end
    lk = 0;
    ow = 0;
    for (int c = 0; c < n; c++) begin
      if (j < exq.size() && exq[j].t + 1 == c) begin
        ta = c;
        b = exq[j].d;
        lk = !exq[j].last;
        ow = (exq[j].r == 1);
        j++;
      end
      k = c - ta;
      tx = (k < 4 || k >= 36) ? (k >= 4) : b[(k - 4) / 4];
      ew[c] = {tx, k < 40, lk, ow};
    end
  endtask

  task automatic run(input int n);
    acc.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      v0 = q0.size() > 0 && c >= st0;
      d0 = v0 ? q0[0].d : 8'h00;
      l0 = v0 && q0[0].last;
      v1 = q1.size() > 0 && c >= st1;
      d1 = v1 ? q1[0].d : 8'h00;
      l1 = v1 && q1[0].last;
      #1;
      obs[c] = {txd, busy, locked, owner};
`ifdef UART_TX_ARB_TIMEOUT_EN
      tlog[c] = tmo;
`else
      tlog[c] = 1'b0;
`endif
      if (v0 && r0) begin acc.push_back('{c, 0, d0, l0}); void'(q0.pop_front()); end
      if (v1 && r1) begin acc.push_back('{c, 1, d1, l1}); void'(q1.pop_front()); end
    end
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic test_reset;
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h33; d1 = 8'h44;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset txd got %b want 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset locked got %b want 0", locked); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset owner got %b want 0", owner); end
    checks++; if ({r0, r1} !== 2'b00) begin errors++; $display("FAIL reset ready got %b want 00", {r0, r1}); end
    v0 = 1'b0; v1 = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    int nb, nl, bad, fc;
    do_reset();
    q0.push_back({1'b1, 8'hA5});
    build_model(60);
    run(60);
    checks++;
    if (acc.size() != exq.size()) begin errors++; $display("FAIL single count got %0d want %0d", acc.size(), exq.size()); end
    for (int i = 0; i < acc.size() && i < exq.size(); i++) begin
      checks++;
      if (acc[i].t != exq[i].t || acc[i].r != exq[i].r || acc[i].d !== exq[i].d) begin errors++; $display("FAIL single accept%0d got t%0d r%0d %h want t%0d r%0d %h", i, acc[i].t, acc[i].r, acc[i].d, exq[i].t, exq[i].r, exq[i].d); end
    end
    bad = 0; fc = 0; nb = 0; nl = 0;
    for (int c = 0; c < 60; c++) begin
      if (obs[c] !== ew[c]) begin if (bad == 0) fc = c; bad++; end
      nb += int'(obs[c][2]);
      nl += int'(obs[c][1]);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL single wave %0d cycles first %0d got %b want %b", bad, fc, obs[fc], ew[fc]); end
    checks++; if (nb != 40) begin errors++; $display("FAIL single busy_len got %0d want 40", nb); end
    checks++; if (nl != 0) begin errors++; $display("FAIL single locked got %0d cycles want 0", nl); end
  endtask

  task automatic test_alternate;
    int bad, fc;
    do_reset();
    repeat (3) begin q0.push_back({1'b1, 8'h11}); q1.push_back({1'b1, 8'h22}); end
    build_model(250);
    run(250);
    checks++;
    if (acc.size() != exq.size()) begin errors++; $display("FAIL alt count got %0d want %0d", acc.size(), exq.size()); end
    for (int i = 0; i < acc.size() && i < exq.size(); i++) begin
      checks++;
      if (acc[i].t != exq[i].t || acc[i].r != exq[i].r || acc[i].d !== exq[i].d) begin errors++; $display("FAIL alt accept%0d got t%0d r%0d %h want t%0d r%0d %h", i, acc[i].t, acc[i].r, acc[i].d, exq[i].t, exq[i].r, exq[i].d); end
    end
    bad = 0; fc = 0;
    for (int c = 0; c < 250; c++) if (obs[c] !== ew[c]) begin if (bad == 0) fc = c; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL alt wave %0d cycles first %0d got %b want %b", bad, fc, obs[fc], ew[fc]); end
  endtask

  task automatic test_lock;
    int bad, fc;
    do_reset();
    q0.push_back({1'b0, 8'h01}); q0.push_back({1'b0, 8'h02}); q0.push_back({1'b1, 8'h03});
    q1.push_back({1'b0, 8'($urandom)}); q1.push_back({1'b1, 8'($urandom)});
    build_model(210);
    run(210);
    checks++;
    if (acc.size() != exq.size()) begin errors++; $display("FAIL lock count got %0d want %0d", acc.size(), exq.size()); end
    for (int i = 0; i < acc.size() && i < exq.size(); i++) begin
      checks++;
      if (acc[i].t != exq[i].t || acc[i].r != exq[i].r || acc[i].d !== exq[i].d) begin errors++; $display("FAIL lock accept%0d got t%0d r%0d %h want t%0d r%0d %h", i, acc[i].t, acc[i].r, acc[i].d, exq[i].t, exq[i].r, exq[i].d); end
    end
    bad = 0; fc = 0;
    for (int c = 0; c < 210; c++) if (obs[c] !== ew[c]) begin if (bad == 0) fc = c; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL lock wave %0d cycles first %0d got %b want %b", bad, fc, obs[fc], ew[fc]); end
  endtask

  task automatic test_reset_mid;
    int bad, fc;
    do_reset();
    q0.push_back({1'b0, 8'h5A});
    build_model(18);
    run(18);
    bad = 0; fc = 0;
    for (int c = 0; c < 18; c++) if (obs[c] !== ew[c]) begin if (bad == 0) fc = c; bad++; end
    checks++; if (bad != 0 || acc.size() != 1) begin errors++; $display("FAIL midrst pre wave %0d cycles accepts %0d first %0d got %b want %b", bad, acc.size(), fc, obs[fc], ew[fc]); end
    @(negedge clk);
    v1 = 1'b1; d1 = 8'h77; l1 = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if ({txd, busy, locked} !== 3'b100) begin errors++; $display("FAIL midrst state got txd,busy,locked=%b want 100", {txd, busy, locked}); end
    checks++; if ({r0, r1} !== 2'b00) begin errors++; $display("FAIL midrst ready got %b want 00", {r0, r1}); end
    @(negedge clk);
    rst = 1'b0;
    v1 = 1'b0;
    q0.delete();
    q1.push_back({1'b1, 8'($urandom)});
    build_model(50);
    run(50);
    checks++;
    if (acc.size() != exq.size()) begin errors++; $display("FAIL midrst count got %0d want %0d", acc.size(), exq.size()); end
    for (int i = 0; i < acc.size() && i < exq.size(); i++) begin
      checks++;
      if (acc[i].t != exq[i].t || acc[i].r != exq[i].r || acc[i].d !== exq[i].d) begin errors++; $display("FAIL midrst accept%0d got t%0d r%0d %h want t%0d r%0d %h", i, acc[i].t, acc[i].r, acc[i].d, exq[i].t, exq[i].r, exq[i].d); end
    end
    bad = 0; fc = 0;
    for (int c = 0; c < 50; c++) if (obs[c] !== ew[c]) begin if (bad == 0) fc = c; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst wave %0d cycles first %0d got %b want %b", bad, fc, obs[fc], ew[fc]); end
  endtask

  task automatic test_back_to_back;
    int bad, fc;
    do_reset();
    q1.push_back({1'b1, 8'hFF}); q1.push_back({1'b1, 8'h00});
    build_model(90);
    run(90);
    checks++;
    if (acc.size() != 2 || acc[1].t - acc[0].t != 41) begin errors++; $display("FAIL b2b spacing got %0d accepts gap %0d want 2 gap 41", acc.size(), acc.size() == 2 ? acc[1].t - acc[0].t : -1); end
    checks++;
    if ({obs[40][3], obs[41][3], obs[42][3]} !== 3'b110) begin errors++; $display("FAIL b2b gap txd got %b want 110", {obs[40][3], obs[41][3], obs[42][3]}); end
    bad = 0; fc = 0;
    for (int c = 0; c < 90; c++) if (obs[c] !== ew[c]) begin if (bad == 0) fc = c; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b wave %0d cycles first %0d got %b want %b", bad, fc, obs[fc], ew[fc]); end
  endtask

  task automatic test_random;
    int bad, fc, len;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int p = 0; p < 2; p++) begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) q0.push_back({i == len - 1, 8'($urandom)});
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) q1.push_back({i == len - 1, 8'($urandom)});
      end
      st0 = $urandom_range(0, 20);
      st1 = $urandom_range(0, 20);
      build_model(600);
      run(600);
      checks++;
      if (acc.size() != exq.size()) begin errors++; $display("FAIL rand%0d count got %0d want %0d", it, acc.size(), exq.size()); end
      for (int i = 0; i < acc.size() && i < exq.size(); i++) begin
        checks++;
        if (acc[i].t != exq[i].t || acc[i].r != exq[i].r || acc[i].d !== exq[i].d) begin errors++; $display("FAIL rand%0d accept%0d got t%0d r%0d %h want t%0d r%0d %h", it, i, acc[i].t, acc[i].r, acc[i].d, exq[i].t, exq[i].r, exq[i].d); end
      end
      bad = 0; fc = 0;
      for (int c = 0; c < 600; c++) if (obs[c] !== ew[c]) begin if (bad == 0) fc = c; bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d wave %0d cycles first %0d got %b want %b", it, bad, fc, obs[fc], ew[fc]); end
    end
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int np, pc;
    do_reset();
    q0.push_back({1'b0, 8'($urandom)});
    q1.push_back({1'b1, 8'($urandom)});
    st1 = 5;
    run(80);
    np = 0; pc = -1;
    for (int c = 0; c < 80; c++) if (tlog[c] === 1'b1) begin np++; pc = c; end
    checks++; if (np != 1 || pc != 61) begin errors++; $display("FAIL timeout pulse got %0d pulses last at %0d want 1 at 61", np, pc); end
    checks++;
    if (acc.size() != 2 || acc[0].r != 0 || acc[0].t != 0 || acc[1].r != 1 || acc[1].t != 61) begin errors++; $display("FAIL timeout grant got %0d accepts second t%0d want req1 at 61", acc.size(), acc.size() > 1 ? acc[1].t : -1); end
    checks++; if ({obs[60][1], obs[61][1]} !== 2'b10) begin errors++; $display("FAIL timeout locked got %b want 10", {obs[60][1], obs[61][1]}); end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef UART_TX_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
